// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct encodings and control enums for the MIPS-subset core.
package cpu_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
  typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JMP, PC_JR} pc_sel_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_LINK} wb_sel_t;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 32-bit ALU; shifts act on b by shamt, lui shifts b by 16.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  result = b << 16;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle MIPS-subset core; PC and register file commit on the rising edge.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_read,
  output logic        mem_write
);
  logic [31:0] pc, pc4, pc_next, rs_val, rt_val, imm_sx, alu_b, alu_res, wb_data;
  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic        use_imm, zext, rd_en, wr_en;
  alu_op_t     alu_op;
  pc_sel_t     pc_sel;
  wb_sel_t     wb_sel;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign funct = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};
  assign pc4 = pc + 32'd4;
  assign instr_addr = pc;
  assign rs_val = rs == 5'd0 ? '0 : regs[rs];
  assign rt_val = rt == 5'd0 ? '0 : regs[rt];
  always_comb begin
    alu_op = ALU_ADD;
    use_imm = 1'b0;
    zext = 1'b0;
    wb_sel = WB_NONE;
    dst = rt;
    pc_sel = PC_SEQ;
    rd_en = 1'b0;
    wr_en = 1'b0;
    case (op)
      OP_R: begin
        dst = rd;
        wb_sel = WB_ALU;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_JR: begin
            wb_sel = WB_NONE;
            pc_sel = PC_JR;
          end
          default: wb_sel = WB_NONE;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; wb_sel = WB_ALU; end
      OP_SLTI:  begin use_imm = 1'b1; wb_sel = WB_ALU; alu_op = ALU_SLT; end
      OP_SLTIU: begin use_imm = 1'b1; wb_sel = WB_ALU; alu_op = ALU_SLTU; end
      OP_ANDI:  begin use_imm = 1'b1; zext = 1'b1; wb_sel = WB_ALU; alu_op = ALU_AND; end
      OP_ORI:   begin use_imm = 1'b1; zext = 1'b1; wb_sel = WB_ALU; alu_op = ALU_OR; end
      OP_XORI:  begin use_imm = 1'b1; zext = 1'b1; wb_sel = WB_ALU; alu_op = ALU_XOR; end
      OP_LUI:   begin use_imm = 1'b1; zext = 1'b1; wb_sel = WB_ALU; alu_op = ALU_LUI; end
      OP_LW:    begin use_imm = 1'b1; wb_sel = WB_MEM; rd_en = 1'b1; end
      OP_SW:    begin use_imm = 1'b1; wr_en = 1'b1; end
      OP_BEQ:   pc_sel = rs_val == rt_val ? PC_BR : PC_SEQ;
      OP_BNE:   pc_sel = rs_val != rt_val ? PC_BR : PC_SEQ;
      OP_J:     pc_sel = PC_JMP;
      OP_JAL:   begin pc_sel = PC_JMP; wb_sel = WB_LINK; dst = 5'd31; end
      default:  pc_sel = PC_SEQ;
    endcase
  end
  assign alu_b = !use_imm ? rt_val : zext ? {16'b0, instr[15:0]} : imm_sx;
  cpu_alu u_alu (
    .a(rs_val),
    .b(alu_b),
    .shamt(instr[10:6]),
    .alu_op(alu_op),
    .result(alu_res)
  );
  assign data_addr = alu_res;
  // Strobes are gated by reset so memory sees no access while reset is held.
  assign mem_read = rd_en & rst;
  assign mem_write = wr_en & rst;
  assign data_out = mem_write ? rt_val : '0;
  assign wb_data = wb_sel == WB_MEM ? data_in : wb_sel == WB_LINK ? pc4 : alu_res;
  assign pc_next = pc_sel == PC_JR  ? rs_val :
                   pc_sel == PC_JMP ? {pc4[31:28], instr[25:0], 2'b00} :
                   pc_sel == PC_BR  ? pc4 + (imm_sx << 2) : pc4;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wb_sel != WB_NONE && dst != 5'd0) regs[dst] <= wb_data;
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven program with a scoreboard queue, plus reset corner sequences.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0, data_in = '0;
  logic [31:0] instr_addr, data_addr, data_out;
  logic        mem_read, mem_write;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] instr, din, pc;
    logic        mr, mw;
    logic [31:0] daddr, dout;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  cpu_core dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic [31:0] d, input logic [31:0] p,
                     input logic r, input logic w, input logic [31:0] a, input logic [31:0] o);
    vec_t v;
    v.instr = i; v.din = d; v.pc = p; v.mr = r; v.mw = w; v.daddr = a; v.dout = o;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    string tag;
    add(32'h20010005, 0, 32'h00, 0, 0, 0, 0);
    add(32'h20020007, 0, 32'h04, 0, 0, 0, 0);
    add(32'h00221820, 0, 32'h08, 0, 0, 0, 0);
    add(32'hAC030004, 0, 32'h0C, 0, 1, 32'h4, 32'hC);
    add(32'h8C040004, 32'hC, 32'h10, 1, 0, 32'h4, 0);
    add(32'h00231022, 0, 32'h14, 0, 0, 0, 0);
    add(32'hAC020000, 0, 32'h18, 0, 1, 32'h0, 32'hFFFFFFF9);
    add(32'hAC040008, 0, 32'h1C, 0, 1, 32'h8, 32'hC);
    add(32'h10210002, 0, 32'h20, 0, 0, 0, 0);
    add(32'h14210002, 0, 32'h2C, 0, 0, 0, 0);
    add(32'h08000004, 0, 32'h30, 0, 0, 0, 0);
    add(32'h0C000008, 0, 32'h10, 0, 0, 0, 0);
    add(32'hAC1F0000, 0, 32'h20, 0, 1, 32'h0, 32'h14);
    add(32'h20000009, 0, 32'h24, 0, 0, 0, 0);
    add(32'hAC000000, 0, 32'h28, 0, 1, 32'h0, 32'h0);
    add(32'hFC000000, 0, 32'h2C, 0, 0, 0, 0);
    add(32'h3405F0F0, 0, 32'h30, 0, 0, 0, 0);
    add(32'h3C068000, 0, 32'h34, 0, 0, 0, 0);
    add(32'h00063903, 0, 32'h38, 0, 0, 0, 0);
    add(32'h00C1402A, 0, 32'h3C, 0, 0, 0, 0);
    add(32'h00C1482B, 0, 32'h40, 0, 0, 0, 0);
    add(32'h00A05027, 0, 32'h44, 0, 0, 0, 0);
    add(32'hAC070000, 0, 32'h48, 0, 1, 32'h0, 32'hF8000000);
    add(32'hAC080000, 0, 32'h4C, 0, 1, 32'h0, 32'h1);
    add(32'hAC090000, 0, 32'h50, 0, 1, 32'h0, 32'h0);
    add(32'hAC0A0000, 0, 32'h54, 0, 1, 32'h0, 32'hFFFF0F0F);
    add(32'h200B0100, 0, 32'h58, 0, 0, 0, 0);
    add(32'h01600008, 0, 32'h5C, 0, 0, 0, 0);
    add(32'hAD65FFFC, 0, 32'h100, 0, 1, 32'hFC, 32'hF0F0);
    add(32'h1000FFFE, 0, 32'h104, 0, 0, 0, 0);
    add(32'h200CFFFF, 0, 32'h100, 0, 0, 0, 0);
    add(32'hAC0C0000, 0, 32'h104, 0, 1, 32'h0, 32'hFFFFFFFF);
    add(32'hAC060000, 0, 32'h108, 0, 1, 32'h0, 32'h80000000);
    add(32'h298D0000, 0, 32'h10C, 0, 0, 0, 0);
    add(32'hAC0D0000, 0, 32'h110, 0, 1, 32'h0, 32'h1);
    add(32'h000677C2, 0, 32'h114, 0, 0, 0, 0);
    add(32'hAC0E0000, 0, 32'h118, 0, 1, 32'h0, 32'h1);

    instr = 32'hAC030004;
    #3;
    chk("reset_pc", instr_addr, 32'h0);
    chk("reset_mem_write", {31'b0, mem_write}, 0);
    chk("reset_mem_read", {31'b0, mem_read}, 0);
    chk("reset_data_out", data_out, 0);
    #4 rst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      instr = vecs[k].instr;
      data_in = vecs[k].din;
      exp_q.push_back(vecs[k]);
      #2;
      e = exp_q.pop_front();
      tag = $sformatf("v%0d", k);
      chk({tag, "_pc"}, instr_addr, e.pc);
      chk({tag, "_mem_read"}, {31'b0, mem_read}, {31'b0, e.mr});
      chk({tag, "_mem_write"}, {31'b0, mem_write}, {31'b0, e.mw});
      chk({tag, "_data_out"}, data_out, e.dout);
      if (e.mr || e.mw) chk({tag, "_data_addr"}, data_addr, e.daddr);
    end

    @(negedge clk);
    instr = 32'hAC030000;
    #1;
    chk("pre_rst_mem_write", {31'b0, mem_write}, 1);
    chk("pre_rst_data_out", data_out, 32'hC);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_mem_write", {31'b0, mem_write}, 0);
    chk("async_rst_data_out", data_out, 0);
    chk("async_rst_pc", instr_addr, 32'h0);
    @(negedge clk);
    chk("held_rst_pc", instr_addr, 32'h0);
    rst = 1'b1;
    #2;
    chk("post_rst_mem_write", {31'b0, mem_write}, 1);
    chk("post_rst_r3_cleared", data_out, 0);
    @(negedge clk);
    instr = 32'hAC1F0000;
    #2;
    chk("post_rst_pc", instr_addr, 32'h4);
    chk("post_rst_r31_cleared", data_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
